// File: rtl/ddr_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_test_pkg
//  Description : Shared types, AXI constants and the beat pattern function
//                for the DDR burst write/readback traffic generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr_test_pkg;

    // Test sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        WR_ADDR  = 3'd2,
        WR_DATA  = 3'd3,
        WR_RESP  = 3'd4,
        RD_ADDR  = 3'd5,
        RD_DATA  = 3'd6,
        FINISH   = 3'd7
    } state_t;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // The pattern function works on the widest supported bus; callers
    // truncate the result to their own data width.
    localparam int unsigned PAT_MAX_LANES = 32;
    localparam int unsigned PAT_MAX_W     = PAT_MAX_LANES * 32;

    // Lane j of global beat n carries seed + n*lanes + j (mod 2^32).
    function automatic logic [PAT_MAX_W-1:0] pattern_beat(
        input logic [31:0] seed,
        input logic [31:0] n,
        input int unsigned lanes
    );
        logic [PAT_MAX_W-1:0] r;
        r = '0;
        for (int j = 0; j < int'(PAT_MAX_LANES); j++) begin
            if (j < int'(lanes)) begin
                r[j*32 +: 32] = seed + n * lanes + 32'(j);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_test_beat_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_test_beat_ctr
//  Description : Beat-within-burst and burst-within-pass counters with
//                last-beat / last-burst flags. Both counters wrap to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_test_beat_ctr
    import ddr_test_pkg::*;
#(
    parameter int BURST_LEN  = 4,
    parameter int NUM_BURSTS = 2,
    parameter int BEAT_W     = $clog2(BURST_LEN + 1),
    parameter int BURST_W    = $clog2(NUM_BURSTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               beat_inc_i,
    input  logic               burst_inc_i,
    output logic [BEAT_W-1:0]  beat_o,
    output logic [BURST_W-1:0] burst_o,
    output logic               last_beat_o,
    output logic               last_burst_o
);

    logic [BEAT_W-1:0]  beat_q,  beat_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    assign last_beat_o  = (beat_q  == BEAT_W'(BURST_LEN - 1));
    assign last_burst_o = (burst_q == BURST_W'(NUM_BURSTS - 1));
    assign beat_o       = beat_q;
    assign burst_o      = burst_q;

    // Next-count logic: clear has priority, otherwise advance and wrap
    always_comb begin
        beat_d  = beat_q;
        burst_d = burst_q;
        if (clr_i) begin
            beat_d  = '0;
            burst_d = '0;
        end else begin
            if (beat_inc_i) begin
                beat_d = last_beat_o ? '0 : beat_q + BEAT_W'(1);
            end
            if (burst_inc_i) begin
                burst_d = last_burst_o ? '0 : burst_q + BURST_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q  <= '0;
            burst_q <= '0;
        end else begin
            beat_q  <= beat_d;
            burst_q <= burst_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_burst_test_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_burst_test_gen
//  Description : DDR AXI4 write/readback traffic generator. Writes
//                NUM_BURSTS INCR bursts of seeded pattern data, reads them
//                back, checks every beat and reports done/pass/err_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_burst_test_gen
    import ddr_test_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 128,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
    parameter int          BURST_LEN  = 4,
    parameter int          NUM_BURSTS = 2,
    parameter logic [31:0] SEED       = 32'h1234_5678
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              ddr_ready_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [7:0]        awlen_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic              wlast_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [15:0]       err_cnt_o
);

    localparam int                LANES      = DATA_W / 32;
    localparam int                BEAT_BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] C_BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] C_STRIDE   = ADDR_W'(BURST_LEN * BEAT_BYTES);
    localparam logic [7:0]        C_AXI_LEN  = 8'(BURST_LEN - 1);
    localparam int                BEAT_W     = $clog2(BURST_LEN + 1);
    localparam int                BURST_W    = $clog2(NUM_BURSTS + 1);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic [ADDR_W-1:0] araddr_q,  araddr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic              wlast_q,   wlast_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              done_q,    done_d;
    logic              pass_q,    pass_d;

    logic [BEAT_W-1:0]  wr_beat,  rd_beat;
    logic [BURST_W-1:0] wr_burst, rd_burst;
    logic               wr_last_beat, wr_last_burst;
    logic               rd_last_beat, rd_last_burst;

    logic              start_go, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              rd_bad, err_inc;
    logic [31:0]       wr_n, rd_n;
    logic [DATA_W-1:0] exp_rdata;

    assign start_go = (state_q == IDLE) && start_i;
    assign aw_hs    = (state_q == WR_ADDR) && awready_i;
    assign w_hs     = (state_q == WR_DATA) && wready_i;
    assign b_hs     = (state_q == WR_RESP) && bvalid_i;
    assign ar_hs    = (state_q == RD_ADDR) && arready_i;
    assign r_hs     = (state_q == RD_DATA) && rvalid_i;

    // Global beat indices feeding the pattern generator
    assign wr_n = 32'(wr_burst) * 32'(BURST_LEN) + 32'(wr_beat);
    assign rd_n = 32'(rd_burst) * 32'(BURST_LEN) + 32'(rd_beat);

    assign exp_rdata = DATA_W'(pattern_beat(SEED, rd_n, LANES));
    // Several faults on one beat still count as a single error
    assign rd_bad    = (rdata_i != exp_rdata) || (rresp_i != RESP_OKAY) ||
                       (rlast_i != rd_last_beat);
    assign err_inc   = (b_hs && (bresp_i != RESP_OKAY)) || (r_hs && rd_bad);

    ddr_test_beat_ctr #(
        .BURST_LEN  (BURST_LEN),
        .NUM_BURSTS (NUM_BURSTS),
        .BEAT_W     (BEAT_W),
        .BURST_W    (BURST_W)
    ) u_wr_ctr (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (start_go),
        .beat_inc_i   (w_hs),
        .burst_inc_i  (b_hs),
        .beat_o       (wr_beat),
        .burst_o      (wr_burst),
        .last_beat_o  (wr_last_beat),
        .last_burst_o (wr_last_burst)
    );

    ddr_test_beat_ctr #(
        .BURST_LEN  (BURST_LEN),
        .NUM_BURSTS (NUM_BURSTS),
        .BEAT_W     (BEAT_W),
        .BURST_W    (BURST_W)
    ) u_rd_ctr (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (start_go),
        .beat_inc_i   (r_hs),
        .burst_inc_i  (r_hs && rd_last_beat),
        .beat_o       (rd_beat),
        .burst_o      (rd_burst),
        .last_beat_o  (rd_last_beat),
        .last_burst_o (rd_last_burst)
    );

    // Sequencer next-state; ddr_ready is only looked at in WAIT_RDY
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_i)     state_d = WAIT_RDY;
            WAIT_RDY: if (ddr_ready_i) state_d = WR_ADDR;
            WR_ADDR:  if (aw_hs)       state_d = WR_DATA;
            WR_DATA:  if (w_hs && wr_last_beat) state_d = WR_RESP;
            WR_RESP:  if (b_hs)        state_d = wr_last_burst ? RD_ADDR : WR_ADDR;
            RD_ADDR:  if (ar_hs)       state_d = RD_DATA;
            RD_DATA:  if (r_hs && rd_last_beat) state_d = rd_last_burst ? FINISH : RD_ADDR;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload and status next-state; payloads only move on their handshake
    always_comb begin
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wlast_d   = wlast_q;
        err_cnt_d = err_cnt_q;
        done_d    = done_q;
        pass_d    = pass_q;

        if (start_go) begin
            awaddr_d  = C_BASE;
            araddr_d  = C_BASE;
            wdata_d   = DATA_W'(pattern_beat(SEED, 32'd0, LANES));
            wlast_d   = 1'b0;
            err_cnt_d = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
        end

        if (aw_hs) begin
            wlast_d = (BURST_LEN == 1);
        end

        if (w_hs) begin
            wdata_d = DATA_W'(pattern_beat(SEED, wr_n + 32'd1, LANES));
            wlast_d = wr_last_beat ? 1'b0 : (32'(wr_beat) + 32'd2 == 32'(BURST_LEN));
        end

        if (b_hs && !wr_last_burst) begin
            awaddr_d = awaddr_q + C_STRIDE;
        end

        if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        // done/pass are set on the final read handshake so they show the
        // very next cycle, including any error found on that beat
        if (r_hs && rd_last_beat) begin
            if (rd_last_burst) begin
                done_d = 1'b1;
                pass_d = (err_cnt_d == 16'd0);
            end else begin
                araddr_d = araddr_q + C_STRIDE;
            end
        end
    end

    // Payload and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awaddr_q  <= C_BASE;
            araddr_q  <= C_BASE;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            err_cnt_q <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wlast_q   <= wlast_d;
            err_cnt_q <= err_cnt_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign awaddr_o  = awaddr_q;
    assign awlen_o   = C_AXI_LEN;
    assign awvalid_o = (state_q == WR_ADDR);
    assign wdata_o   = wdata_q;
    assign wstrb_o   = '1;
    assign wlast_o   = wlast_q;
    assign wvalid_o  = (state_q == WR_DATA);
    assign bready_o  = (state_q == WR_RESP);
    assign araddr_o  = araddr_q;
    assign arlen_o   = C_AXI_LEN;
    assign arvalid_o = (state_q == RD_ADDR);
    assign rready_o  = (state_q == RD_DATA);
    assign busy_o    = (state_q != IDLE) && (state_q != FINISH);
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign err_cnt_o = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_burst_test_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_burst_test_gen
//  Description : Self-checking bench for ddr_burst_test_gen with a reactive
//                AXI slave memory model and table-driven test passes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_burst_test_gen;

    logic         clk = 1'b0;
    logic         rst, start, ddr_ready;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic         awvalid, awready, wlast, wvalid, wready;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready, arvalid, arready, rlast, rvalid, rready;
    logic         busy, done, pass;
    logic [15:0]  err_cnt;

    always #5 clk = ~clk;

    ddr_burst_test_gen #(
        .ADDR_W(32), .DATA_W(128), .BASE_ADDR(32'h0000_F000),
        .BURST_LEN(4), .NUM_BURSTS(2), .SEED(32'h1234_5678)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .ddr_ready_i(ddr_ready),
        .awaddr_o(awaddr), .awlen_o(awlen), .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
        .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
        .araddr_o(araddr), .arlen_o(arlen), .arvalid_o(arvalid), .arready_i(arready),
        .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string sc, input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", sc, nm, act, exp);
        end
    endtask

    // Reference pattern: lane j of beat n = 0x12345678 + 4n + j
    function automatic logic [127:0] tb_pat(input int n);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'h1234_5678 + 32'(n * 4 + j);
        return r;
    endfunction

    // ---------------- slave configuration and bookkeeping ----------------
    bit cfg_bp, cfg_flip, cfg_bresp, cfg_drop;
    logic [127:0] mem [logic [31:0]];
    logic [31:0]  wq[$], rq[$];
    logic [31:0]  aw_addr [4];
    logic [31:0]  ar_addr [4];
    logic [127:0] first_wdata;
    int cyc = 0, last_r_cyc;
    int aw_cnt, ar_cnt, wlast_cnt, w_beats, r_beats, viol, wdata_bad;
    int w_beat, w_burst, r_beat, r_burst, pend_b;
    bit b_hold, r_hold;
    bit p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs, p_wlast;
    logic [31:0]  p_awaddr, p_araddr;
    logic [127:0] p_wdata;

    task automatic slave_clear();
        wq.delete(); rq.delete();
        aw_cnt = 0; ar_cnt = 0; wlast_cnt = 0; w_beats = 0; r_beats = 0;
        viol = 0; wdata_bad = 0; w_beat = 0; w_burst = 0; r_beat = 0; r_burst = 0;
        pend_b = 0; b_hold = 0; r_hold = 0; last_r_cyc = -100;
        p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0; p_wlast = 0;
        first_wdata = '0;
        for (int k = 0; k < 4; k++) begin aw_addr[k] = '0; ar_addr[k] = '0; end
        bvalid = 0; rvalid = 0;
    endtask

    // Reactive AXI slave: decides inputs at negedge from stable DUT outputs
    initial begin : slave
        logic [31:0]  a;
        logic [127:0] d;
        bit aw_hs, w_hs, ar_hs, r_hs;
        forever begin
            @(negedge clk);
            cyc++;
            if (p_awv && !p_awhs && (!awvalid || awaddr != p_awaddr)) viol++;
            if (p_wv && !p_whs && (!wvalid || wdata != p_wdata || wlast != p_wlast)) viol++;
            if (p_arv && !p_arhs && (!arvalid || araddr != p_araddr)) viol++;
            // write data
            wready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wvalid && wq.size() == 0) viol++;
            w_hs = wvalid && wready && (wq.size() > 0);
            if (w_hs) begin
                a = wq[0] + 32'(w_beat * 16);
                mem[a] = wdata;
                if (wdata != tb_pat(w_burst * 4 + w_beat)) wdata_bad++;
                if (w_burst == 0 && w_beat == 0) first_wdata = wdata;
                if (wlast != (w_beat == 3)) viol++;
                if (wstrb != 16'hFFFF) viol++;
                if (wlast) wlast_cnt++;
                w_beats++;
                if (w_beat == 3) begin
                    w_beat = 0; w_burst++; void'(wq.pop_front()); pend_b++;
                end else w_beat++;
            end
            // write address
            awready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            aw_hs = awvalid && awready;
            if (aw_hs) begin
                if (awlen != 8'd3) viol++;
                if (aw_cnt < 4) aw_addr[aw_cnt] = awaddr;
                wq.push_back(awaddr);
                aw_cnt++;
            end
            // write response
            bresp = cfg_bresp ? 2'b10 : 2'b00;
            bvalid = (pend_b > 0) && (b_hold || !cfg_bp || $urandom_range(0, 1) == 1);
            if (bvalid && bready) pend_b--;
            b_hold = bvalid && !bready;
            // read data
            if (rq.size() > 0 && (r_hold || !cfg_bp || $urandom_range(0, 1) == 1)) begin
                a = rq[0] + 32'(r_beat * 16);
                d = mem.exists(a) ? mem[a] : '0;
                if (cfg_flip && r_burst == 1 && r_beat == 2) d[0] = ~d[0];
                rvalid = 1; rdata = d; rresp = 2'b00; rlast = (r_beat == 3);
                if (cfg_drop && r_burst == 1 && r_beat == 3) rlast = 0;
            end else begin
                rvalid = 0; rdata = '0; rresp = 2'b00; rlast = 0;
            end
            r_hs = rvalid && rready;
            r_hold = rvalid && !rready;
            if (r_hs) begin
                r_beats++;
                if (r_beat == 3) begin
                    r_beat = 0; r_burst++; void'(rq.pop_front());
                    if (r_burst == 2) last_r_cyc = cyc;
                end else r_beat++;
            end
            // read address
            arready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            ar_hs = arvalid && arready;
            if (ar_hs) begin
                if (arlen != 8'd3) viol++;
                if (ar_cnt < 4) ar_addr[ar_cnt] = araddr;
                rq.push_back(araddr);
                ar_cnt++;
            end
            p_awv = awvalid; p_awhs = aw_hs; p_awaddr = awaddr;
            p_wv = wvalid; p_whs = w_hs; p_wdata = wdata; p_wlast = wlast;
            p_arv = arvalid; p_arhs = ar_hs; p_araddr = araddr;
        end
    end

    // ---------------- table-driven passes ----------------
    typedef struct {
        string name;
        int    rdy_delay;
        bit    bp;
        bit    flip;
        bit    bresp_err;
        bit    drop_rlast;
        bit    dbl_start;
        int    exp_err;
        bit    exp_pass;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic run_pass(input vec_t v);
        bit pulsed;
        int aw_early;
        cfg_bp = v.bp; cfg_flip = v.flip; cfg_bresp = v.bresp_err; cfg_drop = v.drop_rlast;
        slave_clear();
        ddr_ready = (v.rdy_delay == 0);
        start = 1;
        @(negedge clk); #1;
        start = 0;
        chk(v.name, "busy_after_start", busy, 1);
        chk(v.name, "done_cleared", done, 0);
        if (v.rdy_delay > 0) begin
            aw_early = 0;
            repeat (v.rdy_delay) begin
                @(negedge clk); #1;
                if (awvalid) aw_early++;
            end
            chk(v.name, "aw_before_rdy", aw_early, 0);
            ddr_ready = 1;
        end
        @(negedge clk); #1;
        chk(v.name, "first_awvalid", awvalid, 1);
        pulsed = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk); #1;
            if (v.dbl_start && !pulsed && wvalid) begin start = 1; pulsed = 1; end
            else start = 0;
        end
        start = 0;
        chk(v.name, "done", done, 1);
        chk(v.name, "done_latency", cyc - last_r_cyc, 1);
        chk(v.name, "pass", pass, v.exp_pass);
        chk(v.name, "err_cnt", err_cnt, v.exp_err);
        chk(v.name, "busy_at_done", busy, 0);
        chk(v.name, "aw_cnt", aw_cnt, 2);
        chk(v.name, "ar_cnt", ar_cnt, 2);
        chk(v.name, "aw_addr0", aw_addr[0], 32'h0000_F000);
        chk(v.name, "aw_addr1", aw_addr[1], 32'h0000_F040);
        chk(v.name, "ar_addr1", ar_addr[1], 32'h0000_F040);
        chk(v.name, "wlast_cnt", wlast_cnt, 2);
        chk(v.name, "w_beats", w_beats, 8);
        chk(v.name, "r_beats", r_beats, 8);
        chk(v.name, "protocol", viol, 0);
        chk(v.name, "wdata_bad", wdata_bad, 0);
        chk(v.name, "beat0_wdata", first_wdata, 128'h1234567B_1234567A_12345679_12345678);
        @(negedge clk); #1;
        chk(v.name, "done_held", {done, pass, busy}, {1'b1, v.exp_pass, 1'b0});
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin : main
        bit found;
        vec_t rv;
        rst = 1; start = 0; ddr_ready = 0;
        awready = 0; wready = 0; arready = 0;
        bresp = 0; bvalid = 0; rdata = '0; rresp = 0; rlast = 0; rvalid = 0;
        //          name          dly bp fl br dr ds err pass
        vecs[0] = '{"ideal",       0, 0, 0, 0, 0, 0, 0, 1'b1};
        vecs[1] = '{"rdy_late",   50, 0, 0, 0, 0, 0, 0, 1'b1};
        vecs[2] = '{"flip_bit",    0, 0, 1, 0, 0, 0, 1, 1'b0};
        vecs[3] = '{"backpress",   0, 1, 0, 0, 0, 0, 0, 1'b1};
        vecs[4] = '{"bresp_rlast", 0, 0, 0, 1, 1, 0, 3, 1'b0};
        vecs[5] = '{"dbl_start",   0, 1, 0, 0, 0, 1, 0, 1'b1};

        repeat (3) @(negedge clk);
        #1 rst = 0;
        chk("reset", "busy", busy, 0);
        chk("reset", "done_pass", {done, pass}, 2'b00);
        chk("reset", "err_cnt", err_cnt, 0);
        chk("reset", "valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, 6'b0);

        for (int i = 0; i < NV; i++) run_pass(vecs[i]);

        // Reset in the middle of a write burst, then a clean restart
        cfg_bp = 0; cfg_flip = 0; cfg_bresp = 0; cfg_drop = 0;
        slave_clear();
        ddr_ready = 1;
        start = 1;
        @(negedge clk); #1;
        start = 0;
        found = 0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk); #1;
            if (wvalid && w_beats >= 2) found = 1;
        end
        chk("mid_rst", "reached_wdata", found, 1);
        rst = 1;
        #1;
        chk("mid_rst", "async_drop", {awvalid, wvalid, wlast, bready, arvalid, rready, busy}, 7'b0);
        @(negedge clk); #1;
        rst = 0;
        chk("mid_rst", "idle_after", {busy, done}, 2'b00);
        rv = vecs[0];
        rv.name = "restart";
        run_pass(rv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
